// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//
// Iterative radix-2 shift-add multiplier with an unsigned/signed mode select.
// A single 2*SIZE-bit adder is reused once per cycle. Signed operands are
// reduced to magnitudes when they are captured, and the sign is applied to
// the finished product.
//
// Parameters:
//   SIZE       operand width in bits (>= 2); the product is 2*SIZE bits
//
// Ports:
//   clk        in   1        rising-edge clock
//   reset_n    in   1        asynchronous active-low reset
//   start      in   1        multiply request, sampled only while busy = 0
//   is_signed  in   1        1 = two's-complement operands (captured with start)
//   a          in   SIZE     multiplicand (captured with start)
//   b          in   SIZE     multiplier (captured with start)
//   busy       out  1        high while a multiply is in progress
//   done       out  1        one-cycle pulse when c holds a new product
//   c          out  2*SIZE   product, held until the next completion
//
// Build option:
//   SEQ_MULT_EARLY_TERM_EN  when defined, the multiply finishes as soon as
//                           the remaining multiplier bits are all zero.
//                           Products are the same in both builds.
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int SIZE = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              is_signed,
    input  logic [SIZE-1:0]   a,
    input  logic [SIZE-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*SIZE-1:0] c
);

    localparam int PW = 2 * SIZE;
    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Magnitude of an operand; the most negative value maps to 2^(SIZE-1),
    // which still fits in SIZE unsigned bits.
    function automatic logic [SIZE-1:0] magnitude(input logic [SIZE-1:0] v,
                                                  input logic            sgn);
        logic [SIZE-1:0] m;
        if (sgn && v[SIZE-1]) begin
            m = ~v + {{(SIZE-1){1'b0}}, 1'b1};
        end else begin
            m = v;
        end
        return m;
    endfunction

    state_t          state_q, state_d;
    logic [PW-1:0]   mcand_q, mcand_d;
    logic [SIZE-1:0] mplier_q, mplier_d;
    logic [PW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [PW-1:0]   c_q, c_d;

    logic [PW-1:0]   sum_s;
    logic [PW-1:0]   product_s;
    logic [SIZE-1:0] mplier_nx_s;
    logic            last_s;

    // Datapath for the current iteration: conditional add, shift and the
    // completion test.
    always_comb begin
        if (mplier_q[0]) begin
            sum_s = acc_q + mcand_q;
        end else begin
            sum_s = acc_q;
        end
        mplier_nx_s = mplier_q >> 1;
        // The sign is applied to the sum of the final iteration, so the
        // result is written on the same edge that performs the last add.
        if (neg_q) begin
            product_s = ~sum_s + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            product_s = sum_s;
        end
`ifdef SEQ_MULT_EARLY_TERM_EN
        // Once the remaining multiplier bits are zero no further add can
        // change the accumulator.
        last_s = (cnt_q == CW'(SIZE - 1)) || (mplier_nx_s == {SIZE{1'b0}});
`else
        last_s = (cnt_q == CW'(SIZE - 1));
`endif
    end

    // Next-state and output logic for the IDLE/RUN controller.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        c_d      = c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    mcand_d  = {{SIZE{1'b0}}, magnitude(a, is_signed)};
                    mplier_d = magnitude(b, is_signed);
                    acc_d    = {PW{1'b0}};
                    cnt_d    = {CW{1'b0}};
                    neg_d    = is_signed & (a[SIZE-1] ^ b[SIZE-1]);
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            RUN: begin
                acc_d    = sum_s;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_nx_s;
                cnt_d    = cnt_q + CW'(1);
                if (last_s) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    c_d     = product_s;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mcand_q  <= {PW{1'b0}};
            mplier_q <= {SIZE{1'b0}};
            acc_q    <= {PW{1'b0}};
            cnt_q    <= {CW{1'b0}};
            neg_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_q      <= {PW{1'b0}};
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            c_q      <= c_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign c    = c_q;

endmodule
